// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, buffered
// long-latency results second, with a per-register pending-write mask.
module rf_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [ADDR_W-1:0]          lu_addr,
    input  logic [DATA_W-1:0]          lu_data,
    output logic                       rf_reg_write,
    output logic [ADDR_W-1:0]          rf_write_reg_address,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_live;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              wb_go;
    logic              pop;
    logic              push;
    logic              head_live;
    logic [DEPTH-1:0]  live_nxt;
    logic [ADDR_W-1:0] addr_nxt [DEPTH];
    logic [31:0]       mask_nxt;

    assign lu_ready   = !rst && (count < CW'(DEPTH));
    assign fifo_count = count;
    assign wb_go      = wb_valid && (wb_addr != '0);
    assign pop        = !wb_go && (count != '0);
    assign push       = lu_valid && lu_ready && (lu_addr != '0);
    assign head_live  = q_live[rd_ptr];

    // Live bits and addresses as they will stand after this cycle's
    // kill, pop and push; the mask is built from that view.
    always_comb begin
        live_nxt = q_live;
        mask_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_nxt[i] = q_addr[i];
            if (wb_go && q_addr[i] == wb_addr)
                live_nxt[i] = 1'b0;
        end
        if (pop)
            live_nxt[rd_ptr] = 1'b0;
        if (push) begin
            addr_nxt[wr_ptr] = lu_addr;
            live_nxt[wr_ptr] = !(wb_go && lu_addr == wb_addr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (live_nxt[i])
                mask_nxt = mask_nxt | (32'(1) << addr_nxt[i]);
        end
        mask_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= lu_addr;
            q_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_live               <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            pending_mask         <= '0;
            rf_reg_write         <= 1'b0;
            rf_write_reg_address <= '0;
            rf_write_data        <= '0;
        end else begin
            q_live       <= live_nxt;
            pending_mask <= mask_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            rf_reg_write <= wb_go || (pop && head_live);
            if (wb_go) begin
                rf_write_reg_address <= wb_addr;
                rf_write_data        <= wb_data;
            end else if (pop && head_live) begin
                rf_write_reg_address <= q_addr[rd_ptr];
                rf_write_data        <= q_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the write-port behaviour.
module tb_rf_writeback_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        rf_reg_write;
    logic [4:0]  rf_write_reg_address;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [31:0] exp_mask;
    int          exp_cnt;
    logic        exp_rdy;

    rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .wb_valid(wb_valid),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .lu_valid(lu_valid),
        .lu_ready(lu_ready),
        .lu_addr(lu_addr),
        .lu_data(lu_data),
        .rf_reg_write(rf_reg_write),
        .rf_write_reg_address(rf_write_reg_address),
        .rf_write_data(rf_write_data),
        .pending_mask(pending_mask),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, clock, settle.
    task automatic step(input bit r, input bit wv, input logic [4:0] wa,
                        input logic [31:0] wd, input bit lv,
                        input logic [4:0] la, input logic [31:0] ld);
        bit   rdy;
        bit   go;
        ent_t e;
        rst      = r;
        wb_valid = wv;
        wb_addr  = wa;
        wb_data  = wd;
        lu_valid = lv;
        lu_addr  = la;
        lu_data  = ld;
        rdy = !r && q.size() < DEPTH;
        go  = wv && wa != 0;
        if (r) begin
            q.delete();
            exp_we = 0;
            exp_wa = 0;
            exp_wd = 0;
        end else begin
            if (go) begin
                exp_we = 1;
                exp_wa = wa;
                exp_wd = wd;
                foreach (q[i]) if (q[i].a == wa) q[i].live = 0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                exp_we = e.live;
                if (e.live) begin
                    exp_wa = e.a;
                    exp_wd = e.d;
                end
            end else begin
                exp_we = 0;
            end
            if (lv && rdy && la != 0) begin
                e.a = la;
                e.d = ld;
                e.live = !(go && la == wa);
                q.push_back(e);
            end
        end
        exp_mask = 0;
        foreach (q[i]) if (q[i].live) exp_mask[q[i].a] = 1'b1;
        exp_cnt = q.size();
        exp_rdy = !r && q.size() < DEPTH;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 1, 5, 32'h55);
        step(1, 0, 0, 0, 1, 5, 32'h55);
        tests++;
        if (rf_reg_write !== 1'b0 || rf_write_reg_address !== 5'd0 ||
            rf_write_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_rf got we=%0b a=%0d d=%h want 0/0/0",
                     rf_reg_write, rf_write_reg_address, rf_write_data);
        end
        tests++;
        if (pending_mask !== 32'd0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_state got mask=%h cnt=%0d want 0/0",
                     pending_mask, fifo_count);
        end
        tests++;
        if (lu_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got %0b want 0", lu_ready);
        end
        idle();
        tests++;
        if (lu_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset got %0b want 1", lu_ready);
        end
    endtask

    task automatic test_wb_only();
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        tests++;
        if (rf_reg_write !== 1'b1 || rf_write_reg_address !== 5'd5 ||
            rf_write_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wb_write got we=%0b a=%0d d=%h want 1/5/deadbeef",
                     rf_reg_write, rf_write_reg_address, rf_write_data);
        end
        idle();
        tests++;
        if (rf_reg_write !== 1'b0 || rf_write_reg_address !== 5'd5) begin
            fails++;
            $display("FAIL wb_idle got we=%0b a=%0d want 0/5",
                     rf_reg_write, rf_write_reg_address);
        end
    endtask

    task automatic test_lu_only();
        step(0, 0, 0, 0, 1, 7, 32'h12);
        tests++;
        if (pending_mask[7] !== 1'b1 || rf_reg_write !== 1'b0) begin
            fails++;
            $display("FAIL lu_pending got mask=%h we=%0b want bit7 set/0",
                     pending_mask, rf_reg_write);
        end
        idle();
        tests++;
        if (rf_reg_write !== 1'b1 || rf_write_reg_address !== 5'd7 ||
            rf_write_data !== 32'h12 || pending_mask[7] !== 1'b0) begin
            fails++;
            $display("FAIL lu_write got we=%0b a=%0d d=%h mask=%h want 1/7/12/0",
                     rf_reg_write, rf_write_reg_address, rf_write_data,
                     pending_mask);
        end
        idle();
    endtask

    task automatic test_priority();
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 9, 32'h900 + i, 1, 5'(i), 32'h100 + i);
            tests++;
            if (rf_reg_write !== 1'b1 || rf_write_reg_address !== 5'd9) begin
                fails++;
                $display("FAIL prio_wb%0d got we=%0b a=%0d want 1/9",
                         i, rf_reg_write, rf_write_reg_address);
            end
        end
        tests++;
        if (fifo_count !== 3'd4 || lu_ready !== 1'b0 ||
            pending_mask !== 32'h1E) begin
            fails++;
            $display("FAIL prio_full got cnt=%0d rdy=%0b mask=%h want 4/0/1e",
                     fifo_count, lu_ready, pending_mask);
        end
        for (int i = 1; i <= 4; i++) begin
            idle();
            tests++;
            if (rf_reg_write !== 1'b1 || rf_write_reg_address !== 5'(i) ||
                rf_write_data !== 32'h100 + i) begin
                fails++;
                $display("FAIL drain%0d got we=%0b a=%0d d=%h want 1/%0d/%h",
                         i, rf_reg_write, rf_write_reg_address,
                         rf_write_data, i, 32'h100 + i);
            end
        end
        idle();
        tests++;
        if (rf_reg_write !== 1'b0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL drain_end got we=%0b cnt=%0d want 0/0",
                     rf_reg_write, fifo_count);
        end
    endtask

    task automatic test_waw();
        int r3_writes = 0;
        step(0, 0, 0, 0, 1, 3, 32'hAA);
        step(0, 1, 3, 32'hBB, 0, 0, 0);
        if (rf_reg_write && rf_write_reg_address == 3) r3_writes++;
        tests++;
        if (rf_write_data !== 32'hBB || pending_mask[3] !== 1'b0 ||
            fifo_count !== 3'd1) begin
            fails++;
            $display("FAIL waw_kill got d=%h mask=%h cnt=%0d want bb/0/1",
                     rf_write_data, pending_mask, fifo_count);
        end
        idle();
        if (rf_reg_write && rf_write_reg_address == 3) r3_writes++;
        tests++;
        if (rf_reg_write !== 1'b0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL waw_pop got we=%0b cnt=%0d want 0/0",
                     rf_reg_write, fifo_count);
        end
        idle();
        if (rf_reg_write && rf_write_reg_address == 3) r3_writes++;
        tests++;
        if (r3_writes != 1) begin
            fails++;
            $display("FAIL waw_count got %0d r3 writes want 1", r3_writes);
        end
    endtask

    task automatic test_r0();
        step(0, 1, 0, 32'h77, 1, 0, 32'h88);
        tests++;
        if (rf_reg_write !== 1'b0 || fifo_count !== 3'd0 ||
            pending_mask !== 32'd0) begin
            fails++;
            $display("FAIL r0_ignore got we=%0b cnt=%0d mask=%h want 0/0/0",
                     rf_reg_write, fifo_count, pending_mask);
        end
        step(0, 0, 0, 0, 1, 6, 32'h66);
        step(0, 1, 0, 32'h77, 0, 0, 0);
        tests++;
        if (rf_reg_write !== 1'b1 || rf_write_reg_address !== 5'd6 ||
            rf_write_data !== 32'h66) begin
            fails++;
            $display("FAIL r0_pop got we=%0b a=%0d d=%h want 1/6/66",
                     rf_reg_write, rf_write_reg_address, rf_write_data);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            step(0, 1, 9, 32'h9, 1, 5'(10 + i), 32'(i));
        tests++;
        if (fifo_count !== 3'd3) begin
            fails++;
            $display("FAIL mid_fill got cnt=%0d want 3", fifo_count);
        end
        step(1, 0, 0, 0, 1, 12, 32'h5);
        tests++;
        if (fifo_count !== 3'd0 || pending_mask !== 32'd0 ||
            rf_reg_write !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got cnt=%0d mask=%h we=%0b want 0/0/0",
                     fifo_count, pending_mask, rf_reg_write);
        end
        idle();
        tests++;
        if (rf_reg_write !== 1'b0 || lu_ready !== 1'b1 ||
            fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL mid_after got we=%0b rdy=%0b cnt=%0d want 0/1/0",
                     rf_reg_write, lu_ready, fifo_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
                 $urandom);
            tests++;
            if (rf_reg_write !== exp_we ||
                (exp_we && (rf_write_reg_address !== exp_wa ||
                            rf_write_data !== exp_wd))) begin
                fails++;
                $display("FAIL rnd_write@%0d got %0b/%0d/%h want %0b/%0d/%h",
                         n, rf_reg_write, rf_write_reg_address,
                         rf_write_data, exp_we, exp_wa, exp_wd);
            end
            tests++;
            if (pending_mask !== exp_mask || fifo_count !== 3'(exp_cnt) ||
                lu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rnd_state@%0d got %h/%0d/%0b want %h/%0d/%0b",
                         n, pending_mask, fifo_count, lu_ready,
                         exp_mask, exp_cnt, exp_rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_lu_only();
        test_priority();
        test_waw();
        test_r0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side driver for the 32x32 register file. It merges two write sources onto the single register-file write port:
  - the in-order pipeline writeback, which has priority and no back-pressure;
  - a long-latency unit (multiply/divide, slow loads), buffered in a small FIFO with valid/ready.
- Publishes a per-register pending-write mask so the hazard unit can stall reads of registers whose values are still queued.
- Sits between the WB stage / long-latency unit and the register-file write port.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 4, long-latency FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_addr  in  ADDR_W  pipeline destination register.
- wb_data  in  DATA_W  pipeline write data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept (count < DEPTH and not rst).
- lu_addr  in  ADDR_W  long-latency destination register.
- lu_data  in  DATA_W  long-latency result data.
- rf_reg_write  out  1  register-file write enable (registered).
- rf_write_reg_address  out  ADDR_W  register-file write address (registered).
- rf_write_data  out  DATA_W  register-file write data (registered).
- pending_mask  out  32  bit i = 1 if a live FIFO entry targets register i; bit 0 is always 0.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries, including killed entries.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, all entries invalidated.
  - rf_reg_write=0, rf_write_reg_address=0, rf_write_data=0.
  - pending_mask=0, fifo_count=0.
  - lu_ready=0 while rst=1.
  - Reset mid-drain discards all queued results; no write is issued the cycle after reset.
- rf_* outputs are registered:
  - Decision made in cycle N appears in cycle N+1.
  - Outputs are stable for the full cycle, including the register file's negedge write.
- Per-cycle arbitration, in priority order:
  1. wb_valid=1 and wb_addr!=0: issue the WB write. FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop head.
     - Live head: issue its write.
     - Killed head: rf_reg_write=0 next cycle; the cycle is still consumed.
  3. Otherwise: rf_reg_write=0 next cycle (address/data hold last value).
- Writes to register 0 are never issued:
  - wb_valid with wb_addr=0 is ignored; the FIFO may pop that cycle.
  - lu handshake with lu_addr=0 completes but creates no entry.
- LU handshake:
  - Transfer when lu_valid & lu_ready.
  - lu_ready depends only on count at the start of the cycle; a same-cycle pop does not enable a push when full.
  - Pushed entry is eligible to pop the next cycle at the earliest, so minimum LU-to-rf_reg_write latency is 2 cycles.
  - WB-to-rf_reg_write latency is 1 cycle.
- WAW supersede: a WB write to address X (X!=0) kills every FIFO entry targeting X.
  - Applies to entries present at cycle start and to an entry pushed in the same cycle.
  - Killed entries keep their slot until popped and count in fifo_count.
  - Killed entries clear their pending_mask bit the next cycle.
- pending_mask is registered and reflects FIFO live entries after the current cycle's push/pop/kill.
  - A popped live entry's bit clears in the same cycle its rf_reg_write asserts, unless another live entry targets the same register.
- Full: count=DEPTH -> lu_ready=0; pop continues whenever WB is idle or writes r0.
- Empty with no WB: outputs idle and no state change beyond a possible push.
- Pointers wrap modulo DEPTH.
- fifo_count is never > DEPTH and never underflows.

Test Plan:
- WB only: wb_valid=1, addr=5, data=0xDEADBEEF -> next cycle rf_reg_write=1, addr=5, data=0xDEADBEEF; a following idle cycle gives rf_reg_write=0.
- LU only:
  - stimulus: push addr=7, data=0x12 with WB idle.
  - pending_mask[7]=1 next cycle.
  - rf_reg_write=1 with addr=7, data=0x12 two cycles after the push.
  - pending_mask[7]=0 in that same cycle.
- Priority and back-pressure:
  - stimulus: push 4 LU entries (addr 1..4) while wb_valid=1 every cycle (addr 9).
  - lu_ready=0 at count=4; only addr-9 writes issue.
  - after WB drops, entries 1,2,3,4 write on 4 consecutive cycles in order.
- WAW kill:
  - stimulus: LU pushes addr=3/data=0xAA, then WB writes addr=3/data=0xBB while the entry is still queued.
  - only one write to r3 (0xBB) appears.
  - popping the killed entry yields a cycle with rf_reg_write=0.
  - pending_mask[3] clears right after the kill.
- r0 handling: WB addr=0 and LU addr=0 handshakes -> no rf_reg_write; fifo_count unchanged; pending_mask[0]=0.
- Reset mid-operation: 3 entries queued, rst=1 for one cycle -> fifo_count=0, pending_mask=0, no write issued afterwards, lu_ready=1 the cycle after rst deasserts.
